// File: rtl/zf_detector.sv
// zf_detector: 2x2 MIMO zero-forcing detector, X = H^-1 * (y - n).
//
// Multi-cycle datapath: IDLE -> DET -> NUM -> DIV (33 restoring steps) -> SCALE -> DONE.
// All real components are Q16.16 signed 32-bit values. Every multiply, add and
// subtract saturates to [0x80000000, 0x7FFFFFFF].
//
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous, active-high reset
//   enable     : clock enable; 0 freezes all state and outputs
//   accept_in  : upstream has valid H_matrix / y / n
//   accept_out : block is idle and will capture inputs
//   ready_out  : one-cycle pulse, X holds a new result
//   H_matrix   : h11[255:192] h12[191:128] h21[127:64] h22[63:0], each {re, im}
//   y, n       : element1[127:64] element2[63:0], each {re, im}
//   X          : x1[127:64] x2[63:0], each {re, im}
//
// Build option: define ZF_NOISE_SUB_EN to subtract n from y; otherwise n is ignored.

module zf_detector (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         accept_in,
    output logic         accept_out,
    output logic         ready_out,
    input  logic [255:0] H_matrix,
    input  logic [127:0] y,
    input  logic [127:0] n,
    output logic [127:0] X
);

    typedef enum logic [2:0] {S_IDLE, S_DET, S_NUM, S_DIV, S_SCALE, S_DONE} state_t;

    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
    } cplx_t;

    localparam logic signed [63:0] QMAX     = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] QMIN     = 64'shFFFF_FFFF_8000_0000;
    localparam logic [5:0]         DIV_LAST = 6'd32;

    function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
        logic signed [31:0] r;
        if (v > QMAX)      r = 32'sh7FFF_FFFF;
        else if (v < QMIN) r = 32'sh8000_0000;
        else               r = v[31:0];
        return r;
    endfunction

    function automatic logic signed [31:0] qmul(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return sat32(p >>> 16);
    endfunction

    function automatic logic signed [31:0] qadd(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] s;
        s = 64'(a) + 64'(b);
        return sat32(s);
    endfunction

    function automatic logic signed [31:0] qsub(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] s;
        s = 64'(a) - 64'(b);
        return sat32(s);
    endfunction

    function automatic cplx_t cmul(input cplx_t a, input cplx_t b);
        cplx_t r;
        r.re = qsub(qmul(a.re, b.re), qmul(a.im, b.im));
        r.im = qadd(qmul(a.re, b.im), qmul(a.im, b.re));
        return r;
    endfunction

    // u * conj(d), expanded so the conjugate never needs a saturating negate
    function automatic cplx_t cmulc(input cplx_t u, input cplx_t d);
        cplx_t r;
        r.re = qadd(qmul(u.re, d.re), qmul(u.im, d.im));
        r.im = qsub(qmul(u.im, d.re), qmul(u.re, d.im));
        return r;
    endfunction

    function automatic cplx_t csub(input cplx_t a, input cplx_t b);
        cplx_t r;
        r.re = qsub(a.re, b.re);
        r.im = qsub(a.im, b.im);
        return r;
    endfunction

    state_t       r_state, w_next;
    cplx_t        r_h11, r_h12, r_h21, r_h22;
    cplx_t        r_y1, r_y2;
    cplx_t        r_det, r_v1, r_v2;
    logic [31:0]  r_d, r_rem;
    logic [32:0]  r_quo;
    logic [5:0]   r_cnt;
    logic [127:0] r_x;
    logic         r_ready, r_accept;

`ifdef ZF_NOISE_SUB_EN
    cplx_t        r_n1, r_n2;
`else
    logic         w_unused_n;
    assign w_unused_n = ^n;
`endif

    logic         w_capture;
    cplx_t        w_det, w_y1_eff, w_y2_eff, w_v1, w_v2, w_x1, w_x2;
    logic [31:0]  w_d, w_recip;
    logic [32:0]  w_trial;
    logic         w_take;

    // Capture only when accept_out is visible, so the cycle right after reset never captures.
    assign w_capture = accept_in & r_accept;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_capture) w_next = S_DET;
            S_DET:   w_next = S_NUM;
            S_NUM:   w_next = S_DIV;
            S_DIV:   if (r_cnt == DIV_LAST) w_next = S_SCALE;
            S_SCALE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_det = csub(cmul(r_h11, r_h22), cmul(r_h12, r_h21));
        w_d   = qadd(qmul(w_det.re, w_det.re), qmul(w_det.im, w_det.im));
`ifdef ZF_NOISE_SUB_EN
        w_y1_eff = csub(r_y1, r_n1);
        w_y2_eff = csub(r_y2, r_n2);
`else
        w_y1_eff = r_y1;
        w_y2_eff = r_y2;
`endif
        // r_y1/r_y2 already hold y_eff once DET has run
        w_v1 = cmulc(csub(cmul(r_h22, r_y1), cmul(r_h12, r_y2)), r_det);
        w_v2 = cmulc(csub(cmul(r_h11, r_y2), cmul(r_h21, r_y1)), r_det);

        // Dividend 2^32 has a single set bit, fed in on the first of 33 steps.
        w_trial = {r_rem, r_cnt == 6'd0};
        w_take  = (w_trial >= {1'b0, r_d});

        if (r_d == '0)                  w_recip = '0;
        else if (r_quo[32:31] != 2'b00) w_recip = 32'h7FFF_FFFF;
        else                            w_recip = r_quo[31:0];

        w_x1.re = qmul(r_v1.re, $signed(w_recip));
        w_x1.im = qmul(r_v1.im, $signed(w_recip));
        w_x2.re = qmul(r_v2.re, $signed(w_recip));
        w_x2.im = qmul(r_v2.im, $signed(w_recip));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_h11    <= '0;
            r_h12    <= '0;
            r_h21    <= '0;
            r_h22    <= '0;
            r_y1     <= '0;
            r_y2     <= '0;
            r_det    <= '0;
            r_v1     <= '0;
            r_v2     <= '0;
            r_d      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_x      <= '0;
            r_ready  <= 1'b0;
            r_accept <= 1'b0;
`ifdef ZF_NOISE_SUB_EN
            r_n1     <= '0;
            r_n2     <= '0;
`endif
        end else if (enable) begin
            r_state  <= w_next;
            r_accept <= (w_next == S_IDLE);
            r_ready  <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_h11 <= H_matrix[255:192];
                        r_h12 <= H_matrix[191:128];
                        r_h21 <= H_matrix[127:64];
                        r_h22 <= H_matrix[63:0];
                        r_y1  <= y[127:64];
                        r_y2  <= y[63:0];
`ifdef ZF_NOISE_SUB_EN
                        r_n1  <= n[127:64];
                        r_n2  <= n[63:0];
`endif
                    end
                end
                S_DET: begin
                    r_det <= w_det;
                    r_d   <= w_d;
                    r_y1  <= w_y1_eff;
                    r_y2  <= w_y2_eff;
                end
                S_NUM: begin
                    r_v1  <= w_v1;
                    r_v2  <= w_v2;
                    r_rem <= '0;
                    r_quo <= '0;
                    r_cnt <= '0;
                end
                S_DIV: begin
                    r_cnt <= r_cnt + 6'd1;
                    // Singular H: counter still runs so latency is unchanged
                    if (r_d != '0) begin
                        if (w_take) r_rem <= 32'(w_trial - {1'b0, r_d});
                        else        r_rem <= w_trial[31:0];
                        r_quo <= {r_quo[31:0], w_take};
                    end
                end
                S_SCALE: r_x <= {w_x1, w_x2};
                default: ;
            endcase
        end
    end

    assign accept_out = r_accept;
    assign ready_out  = r_ready;
    assign X          = r_x;

endmodule

// File: tb/tb_zf_detector.sv
// Testbench for zf_detector: directed table + random vectors against a
// Q16.16 arithmetic reference model, plus stall, held-pulse and abort sequences.
module tb_zf_detector;

    logic         clk = 1'b0;
    logic         reset, enable, accept_in;
    logic         accept_out, ready_out;
    logic [255:0] H_matrix;
    logic [127:0] y, n, X;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    zf_detector dut (
        .clk(clk), .reset(reset), .enable(enable), .accept_in(accept_in),
        .accept_out(accept_out), .ready_out(ready_out),
        .H_matrix(H_matrix), .y(y), .n(n), .X(X)
    );

`ifdef ZF_NOISE_SUB_EN
    localparam bit NOISE_ON = 1'b1;
`else
    localparam bit NOISE_ON = 1'b0;
`endif

    localparam longint QMAX = 64'sd2147483647;
    localparam longint QMIN = -64'sd2147483648;
    localparam int ONE = 65536;

    typedef struct { int re; int im; } cx_t;

    typedef struct {
        string        name;
        logic [255:0] h;
        logic [127:0] y;
        logic [127:0] n;
        logic [127:0] x;
    } vec_t;

    vec_t vecs[$];

    function automatic int sat(input longint v);
        if (v > QMAX) return int'(QMAX);
        if (v < QMIN) return int'(QMIN);
        return int'(v);
    endfunction

    function automatic int fm(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return sat(p >>> 16);
    endfunction

    function automatic cx_t cm(input cx_t a, input cx_t b);
        cx_t r;
        r.re = sat(longint'(fm(a.re, b.re)) - longint'(fm(a.im, b.im)));
        r.im = sat(longint'(fm(a.re, b.im)) + longint'(fm(a.im, b.re)));
        return r;
    endfunction

    function automatic cx_t cmc(input cx_t u, input cx_t d);
        cx_t r;
        r.re = sat(longint'(fm(u.re, d.re)) + longint'(fm(u.im, d.im)));
        r.im = sat(longint'(fm(u.im, d.re)) - longint'(fm(u.re, d.im)));
        return r;
    endfunction

    function automatic cx_t cs(input cx_t a, input cx_t b);
        cx_t r;
        r.re = sat(longint'(a.re) - longint'(b.re));
        r.im = sat(longint'(a.im) - longint'(b.im));
        return r;
    endfunction

    function automatic cx_t unpk(input logic [63:0] v);
        cx_t r;
        r.re = $signed(v[63:32]);
        r.im = $signed(v[31:0]);
        return r;
    endfunction

    function automatic logic [63:0] pk(input int re, input int im);
        return {re, im};
    endfunction

    // X = H^-1 (y - n) using adjugate / determinant, 1/D = floor(2^32 / D)
    function automatic logic [127:0] zf_model(input logic [255:0] h, input logic [127:0] yv,
                                              input logic [127:0] nv);
        cx_t h11, h12, h21, h22, y1, y2, dt, v1, v2;
        longint dd, q;
        int r;
        h11 = unpk(h[255:192]); h12 = unpk(h[191:128]);
        h21 = unpk(h[127:64]);  h22 = unpk(h[63:0]);
        y1  = unpk(yv[127:64]); y2  = unpk(yv[63:0]);
        if (NOISE_ON) begin
            y1 = cs(y1, unpk(nv[127:64]));
            y2 = cs(y2, unpk(nv[63:0]));
        end
        dt = cs(cm(h11, h22), cm(h12, h21));
        dd = sat(longint'(fm(dt.re, dt.re)) + longint'(fm(dt.im, dt.im)));
        if (dd == 0) r = 0;
        else begin
            q = 64'sd4294967296 / dd;
            r = (q > QMAX) ? int'(QMAX) : int'(q);
        end
        v1 = cmc(cs(cm(h22, y1), cm(h12, y2)), dt);
        v2 = cmc(cs(cm(h11, y2), cm(h21, y1)), dt);
        return {fm(v1.re, r), fm(v1.im, r), fm(v2.re, r), fm(v2.im, r)};
    endfunction

    function automatic int rq(input int lim);
        return int'($urandom_range(0, 2 * lim)) - lim;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input string nm, input logic [255:0] h, input logic [127:0] yv,
                           input logic [127:0] nv, input logic [127:0] xv);
        vec_t v;
        v.name = nm; v.h = h; v.y = yv; v.n = nv; v.x = xv;
        vecs.push_back(v);
    endtask

    // Capture one input set and count edges until ready_out; garbage with
    // accept_in=1 is driven mid-operation and must be ignored.
    task automatic run_op(input string nm, input logic [255:0] h, input logic [127:0] yv,
                          input logic [127:0] nv, input int stall_at, input int stall_len,
                          output int lat, output logic [127:0] xo);
        int k;
        k = 0;
        while (!accept_out && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!accept_out) chk({nm, "_accept_wait"}, 128'(accept_out), 128'd1);
        H_matrix = h; y = yv; n = nv; accept_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_busy_accept"}, 128'(accept_out), 128'd0);
        accept_in = 1'b0;
        lat = -1;
        k = 0;
        while (k < 100) begin
            if (k == 3) begin
                H_matrix = {8{$urandom}}; y = {4{$urandom}}; n = {4{$urandom}};
            end
            accept_in = (k >= 3 && k < 8);
            if (k == stall_at) enable = 1'b0;
            if (k == stall_at + stall_len) enable = 1'b1;
            @(posedge clk);
            k++;
            @(negedge clk);
            if (ready_out) begin
                lat = k;
                break;
            end
        end
        accept_in = 1'b0;
        enable = 1'b1;
        xo = X;
    endtask

    task automatic after_op(input string nm);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_pulse_width"}, 128'(ready_out), 128'd0);
        chk({nm, "_accept_again"}, 128'(accept_out), 128'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, pulses;
        logic [127:0] xo, x_ident;
        logic [255:0] h_ident, hr;
        logic [127:0] yr, nr;

        reset = 1'b1; enable = 1'b1; accept_in = 1'b0;
        H_matrix = '0; y = '0; n = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_accept", 128'(accept_out), 128'd0);
        chk("reset_ready", 128'(ready_out), 128'd0);
        chk("reset_X", X, 128'd0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("accept_after_reset", 128'(accept_out), 128'd1);

        h_ident = {pk(ONE, 0), pk(0, 0), pk(0, 0), pk(ONE, 0)};
        x_ident = {32'h0003_0000, 32'h0001_0000, 32'hFFFE_0000, 32'h0000_0000};

        add_vec("identity", h_ident, {pk(3 * ONE, ONE), pk(-2 * ONE, 0)}, '0, x_ident);
        add_vec("diag2", {pk(2 * ONE, 0), pk(0, 0), pk(0, 0), pk(2 * ONE, 0)},
                {pk(4 * ONE, 0), pk(2 * ONE, 0)}, '0, {pk(2 * ONE, 0), pk(ONE, 0)});
        add_vec("noise", h_ident, {pk(32'h0001_8000, 0), pk(0, 0)}, {pk(32'h0000_8000, 0), pk(0, 0)},
                NOISE_ON ? {pk(ONE, 0), pk(0, 0)} : {pk(32'h0001_8000, 0), pk(0, 0)});
        add_vec("singular", {4{pk(ONE, 0)}}, {pk(3 * ONE, ONE), pk(5 * ONE, -2 * ONE)}, '0, '0);
        add_vec("complex", {pk(ONE, ONE), pk(0, 0), pk(0, 0), pk(ONE, -ONE)},
                {pk(2 * ONE, 0), pk(0, 2 * ONE)}, '0,
                {pk(ONE, -ONE), pk(-ONE, ONE)});
        add_vec("recip_sat", {pk(32'h1000, 0), pk(0, 0), pk(0, 0), pk(32'h1000, 0)},
                {pk(ONE, 0), pk(0, 0)}, '0, {pk(32'h0007_FFFF, 0), pk(0, 0)});
        for (int i = 0; i < 12; i++) begin
            hr = {pk(rq(4 * ONE), rq(4 * ONE)), pk(rq(4 * ONE), rq(4 * ONE)),
                  pk(rq(4 * ONE), rq(4 * ONE)), pk(rq(4 * ONE), rq(4 * ONE))};
            yr = {pk(rq(8 * ONE), rq(8 * ONE)), pk(rq(8 * ONE), rq(8 * ONE))};
            nr = {pk(rq(ONE), rq(ONE)), pk(rq(ONE), rq(ONE))};
            add_vec($sformatf("rand%0d", i), hr, yr, nr, zf_model(hr, yr, nr));
        end

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].h, vecs[i].y, vecs[i].n, -1, 0, lat, xo);
            chk({vecs[i].name, "_latency"}, 128'(lat), 128'd36);
            chk({vecs[i].name, "_X"}, xo, vecs[i].x);
            after_op(vecs[i].name);
        end

        // enable low for 10 edges during DIV
        run_op("stall", h_ident, {pk(3 * ONE, ONE), pk(-2 * ONE, 0)}, '0, 10, 10, lat, xo);
        chk("stall_latency", 128'(lat), 128'd46);
        chk("stall_X", xo, x_ident);
        after_op("stall");

        // ready_out coinciding with enable=0 is held
        run_op("hold", h_ident, {pk(3 * ONE, ONE), pk(-2 * ONE, 0)}, '0, -1, 0, lat, xo);
        chk("hold_latency", 128'(lat), 128'd36);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_ready", 128'(ready_out), 128'd1);
        chk("hold_X", X, x_ident);
        chk("hold_accept", 128'(accept_out), 128'd0);
        enable = 1'b1;
        after_op("hold");

        // reset during DIV aborts the operation
        H_matrix = {pk(2 * ONE, 0), pk(0, 0), pk(0, 0), pk(2 * ONE, 0)};
        y = {pk(4 * ONE, 0), pk(2 * ONE, 0)};
        n = '0;
        accept_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        accept_in = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_X", X, 128'd0);
        chk("abort_ready", 128'(ready_out), 128'd0);
        chk("abort_accept", 128'(accept_out), 128'd0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_accept_release", 128'(accept_out), 128'd1);
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ready_out) pulses++;
        end
        chk("abort_no_ready", 128'(pulses), 128'd0);
        chk("abort_X_held", X, 128'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
